// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch front end with a small
// PC-tagged FIFO, redirect/flush and sticky misaligned-target exception.
// Revision: 1.0
`default_nettype none

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_except
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       w_fetch_pc_nxt;
  logic [31:0]       r_q_pc   [QDEPTH];
  logic [31:0]       r_q_inst [QDEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_can_fetch;
  logic w_push;
  logic w_pop;
  logic w_redirect;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_can_fetch  = (r_state == ST_RUN) && (r_count < CNT_W'(QDEPTH));
  assign imem_req     = w_can_fetch;
  assign imem_addr    = r_fetch_pc;
  assign w_push       = w_can_fetch && imem_ack;
  assign inst_valid   = (r_count != '0) && (r_state != ST_HALT);
  assign w_pop        = inst_valid && inst_ready;
  assign w_redirect   = redirect && (r_state != ST_HALT);
  assign fetch_except = (r_state == ST_HALT);
  assign inst         = r_q_inst[r_rd_ptr];
  assign inst_pc      = r_q_pc[r_rd_ptr];

  // Redirect outranks everything; a misaligned target parks the unit in HALT.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      ST_BUBBLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_push) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_BUBBLE;
    endcase
    if (w_redirect) begin
      w_fetch_pc_nxt = r_fetch_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        w_state_nxt    = ST_BUBBLE;
        w_fetch_pc_nxt = redirect_pc;
      end else begin
        w_state_nxt    = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_BUBBLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (w_push && !w_redirect) begin
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      r_q_inst[r_wr_ptr] <= imem_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, hand-written
// redirect corner sequences and randomized traffic against a queue-based model.
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_unit;

  localparam logic [31:0] RPC = 32'h00400000;
  localparam int          QD  = 2;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_except;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address it is asked for.
  assign imem_data = imem_addr ^ KEY;

  inst_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_except(fetch_except)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, fetch pointer and a queue of fetched PCs.
  typedef enum {M_BUB, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode;
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    #1;
    chk("async_rst_req",    {31'b0, imem_req},     32'd0);
    chk("async_rst_valid",  {31'b0, inst_valid},   32'd0);
    chk("async_rst_except", {31'b0, fetch_except}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_mode = M_BUB; m_fpc = RPC; m_q.delete();
    chk("rst_addr", imem_addr, RPC);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_exc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'h00400000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h00400000, 32'h00400004, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00400000, 32'h00400008, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00400000, 32'h00400008, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h00400004, 32'h00400008, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h00400008, 32'h0040000C, 1'b0};
    tbl[6]  = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000004, 1'b0};
    tbl[10] = '{1'b1, 32'h00400102, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00000004, 1'b1};
    tbl[11] = '{1'b1, 32'h00400200, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00000004, 1'b1};

    do_reset();
    chk("rst_req",   {31'b0, imem_req},   32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);

    // Directed vectors, memory acks every request.
    for (int i = 0; i < 12; i++) begin
      imem_ack = 1'b1; inst_ready = tbl[i].rdy;
      redirect = tbl[i].rdr; redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("v%0d_req", i),    {31'b0, imem_req},     {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d_valid", i),  {31'b0, inst_valid},   {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d_addr", i),   imem_addr,             tbl[i].e_addr);
      chk($sformatf("v%0d_except", i), {31'b0, fetch_except}, {31'b0, tbl[i].e_exc});
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),   inst_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_inst", i), inst,    tbl[i].e_pc ^ KEY);
      end
    end

    // Reset out of HALT, then fetch resumes at the reset PC.
    do_reset();
    imem_ack = 1'b0; inst_ready = 1'b1; redirect = 1'b0;
    step();
    chk("resume_req",  {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, RPC);

    // Redirect while a slow transaction is pending: stale word must vanish.
    step();
    redirect = 1'b1; redirect_pc = 32'h00400100;
    step();
    redirect = 1'b0;
    chk("abandon_req",   {31'b0, imem_req},   32'd0);
    chk("abandon_valid", {31'b0, inst_valid}, 32'd0);
    chk("abandon_addr",  imem_addr, 32'h00400100);
    step();
    chk("reissue_req",  {31'b0, imem_req}, 32'd1);
    chk("reissue_addr", imem_addr, 32'h00400100);
    imem_ack = 1'b1;
    step();
    chk("reissue_pc",   inst_pc, 32'h00400100);
    chk("reissue_inst", inst,    32'h00400100 ^ KEY);

    // Redirect coinciding with ack and pop: acked word dropped, FIFO empty.
    redirect = 1'b1; redirect_pc = 32'h00400300;
    step();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("rdack_valid", {31'b0, inst_valid}, 32'd0);
    chk("rdack_req",   {31'b0, imem_req},   32'd0);
    chk("rdack_addr",  imem_addr, 32'h00400300);

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic m_req, m_valid, a, r, d;
      logic [31:0] p;
      if (cyc % 300 == 299) do_reset();
      m_req   = (m_mode == M_RUN) && (m_q.size() < QD);
      m_valid = (m_q.size() != 0);
      chk("rnd_req",    {31'b0, imem_req},     {31'b0, m_req});
      chk("rnd_valid",  {31'b0, inst_valid},   {31'b0, m_valid});
      chk("rnd_addr",   imem_addr,             m_fpc);
      chk("rnd_except", {31'b0, fetch_except}, {31'b0, (m_mode == M_HALT)});
      if (m_valid) begin
        chk("rnd_pc",   inst_pc, m_q[0]);
        chk("rnd_inst", inst,    m_q[0] ^ KEY);
      end
      a = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       p = 32'hFFFFFFF8;
        1:       p = {$urandom_range(0, 65535), 16'h0} | 32'h2;
        default: p = {$urandom, 2'b00} >> 0 & 32'hFFFFFFFC;
      endcase
      imem_ack = a; inst_ready = r; redirect = d; redirect_pc = p;
      @(posedge clk);
      if (m_mode != M_HALT) begin
        if (d) begin
          m_q.delete();
          if (p[1:0] == 2'b00) begin
            m_fpc  = p;
            m_mode = M_BUB;
          end else begin
            m_mode = M_HALT;
          end
        end else begin
          if (m_valid && r) void'(m_q.pop_front());
          if (m_req && a) begin
            m_q.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
          end
          if (m_mode == M_BUB) m_mode = M_RUN;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
